// File: rtl/mux_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined word mux.
// No ports. Every helper is a constant function, so it can size generate
// blocks and set localparams.
package mux_pkg;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Number of pipeline stages. This is the ceiling of sel_w / lps.
  function automatic int mux_stages(input int sel_w, input int lps);
    return (sel_w + lps - 1) / lps;
  endfunction

  // Number of words still alive after stage k has registered.
  // When k = -1, the result is the unreduced input count.
  function automatic int stage_words(input int inputs, input int k, input int lps);
    return inputs >> min_int($clog2(inputs), (k + 1) * lps);
  endfunction

  // Number of tree levels that stage k resolves. The last stage may resolve
  // fewer levels than lps, because the count is clipped to the select width.
  function automatic int stage_levels(input int inputs, input int k, input int lps);
    return min_int($clog2(inputs), (k + 1) * lps) - k * lps;
  endfunction

  function automatic bit mux_params_ok(input int inputs, input int lps);
    return (inputs >= 2) && ((inputs & (inputs - 1)) == 0) &&
           (lps >= 1) && (lps <= $clog2(inputs));
  endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One pipeline stage of the word mux. The stage is a combinational
// 2^LEVELS:1 reduction followed by a register that loads when adv is high.
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   adv                   the register loads this cycle
//   in_valid/in_words     incoming words (IN_WORDS of DATA_W bits)
//   in_sel                full select word. Bits [SEL_LO +: LEVELS] are used here.
//   out_valid/out_words   registered survivors (OUT_WORDS of DATA_W bits)
//   out_sel               registered full select word, carried for the echo
module mux_pipe_stage
  import mux_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IN_WORDS  = 2,
  parameter int LEVELS    = 1,
  parameter int SEL_W     = 1,
  parameter int SEL_LO    = 0,
  parameter int OUT_WORDS = IN_WORDS >> LEVELS
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          adv,
  input  logic                          in_valid,
  input  logic [IN_WORDS*DATA_W-1:0]    in_words,
  input  logic [SEL_W-1:0]              in_sel,
  output logic                          out_valid,
  output logic [OUT_WORDS*DATA_W-1:0]   out_words,
  output logic [SEL_W-1:0]              out_sel
);

  logic [OUT_WORDS*DATA_W-1:0] reduced;

  // Each level halves the word count. Select bit SEL_LO+l picks the odd
  // word or the even word of each pair, so the LSB is resolved first.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = IN_WORDS >> l;
    localparam int NO = IN_WORDS >> (l + 1);
    logic [NI*DATA_W-1:0] src;
    logic [NO*DATA_W-1:0] dst;

    if (l == 0) begin : g_first
      assign src = in_words;
    end else begin : g_next
      assign src = g_lvl[l-1].dst;
    end

    for (genvar j = 0; j < NO; j++) begin : g_pair
      assign dst[j*DATA_W +: DATA_W] = in_sel[SEL_LO + l]
                                     ? src[(2*j+1)*DATA_W +: DATA_W]
                                     : src[(2*j)*DATA_W +: DATA_W];
    end
  end

  assign reduced = g_lvl[LEVELS-1].dst;

  // Payload is loaded together with the valid bit. A bubble therefore
  // carries don't-care data that nobody observes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_words <= '0;
      out_sel   <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_words <= reduced;
      out_sel   <= in_sel;
    end
  end

endmodule

// File: rtl/mux_pipelined.sv
// Pipelined N:1 word multiplexer with valid/ready flow control.
// A register sits after every LEVELS_PER_STAGE levels of the 2:1 tree, and
// the select word travels along with the data so that it can be echoed.
//
// Handshake: a word moves across an interface on a rising clk edge when
// valid and ready are both high on that interface. Valid never depends
// combinationally on ready. in_ready is combinational in out_ready and in
// the stage valid bits, so bubbles collapse and the block sustains one
// word per cycle.
//
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   in_data              INPUTS words. Word i is at [i*DATA_W +: DATA_W].
//   in_sel               index of the word to forward
//   in_valid/in_ready    input handshake
//   out_data/out_sel     selected word and the select value that produced it
//   out_valid/out_ready  output handshake
module mux_pipelined
  import mux_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int INPUTS           = 32,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [INPUTS*DATA_W-1:0]    in_data,
  input  logic [$clog2(INPUTS)-1:0]   in_sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(INPUTS)-1:0]   out_sel,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int SEL_W  = $clog2(INPUTS);
  localparam int LPS    = LEVELS_PER_STAGE;
  localparam int STAGES = mux_stages(SEL_W, LPS);

  if (!mux_params_ok(INPUTS, LPS)) begin : g_bad_params
    $error("mux_pipelined: INPUTS must be a power of two >= 2 and LEVELS_PER_STAGE in 1..SEL_W");
  end

  // adv[k]: stage k may load this cycle. A stage loads when it is empty or
  // when its content moves on. The chain ends at the output handshake.
  logic [STAGES:0] adv;
  assign adv[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_N  = stage_words(INPUTS, k - 1, LPS);
    localparam int OUT_N = stage_words(INPUTS, k, LPS);
    localparam int LV    = stage_levels(INPUTS, k, LPS);

    logic [IN_N*DATA_W-1:0]  words_d;
    logic [SEL_W-1:0]        sel_d;
    logic                    valid_d;
    logic [OUT_N*DATA_W-1:0] words_q;
    logic [SEL_W-1:0]        sel_q;
    logic                    valid_q;

    if (k == 0) begin : g_head
      assign words_d = in_data;
      assign sel_d   = in_sel;
      assign valid_d = in_valid;
    end else begin : g_link
      assign words_d = g_stage[k-1].words_q;
      assign sel_d   = g_stage[k-1].sel_q;
      assign valid_d = g_stage[k-1].valid_q;
    end

    mux_pipe_stage #(
      .DATA_W   (DATA_W),
      .IN_WORDS (IN_N),
      .LEVELS   (LV),
      .SEL_W    (SEL_W),
      .SEL_LO   (k * LPS)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .adv       (adv[k]),
      .in_valid  (valid_d),
      .in_words  (words_d),
      .in_sel    (sel_d),
      .out_valid (valid_q),
      .out_words (words_q),
      .out_sel   (sel_q)
    );

    assign adv[k] = !valid_q || adv[k+1];
  end

  assign in_ready  = adv[0];
  assign out_data  = g_stage[STAGES-1].words_q;
  assign out_sel   = g_stage[STAGES-1].sel_q;
  assign out_valid = g_stage[STAGES-1].valid_q;

  a_sel_known : assert property (@(posedge clk) disable iff (!reset_n)
                                 in_valid |-> !$isunknown(in_sel))
    else $error("mux_pipelined: in_sel unknown while in_valid is high");

endmodule

// File: tb/tb_mux_pipelined.sv
module tb_mux_pipelined;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Main instance: INPUTS=8, DATA_W=8, LPS=1, which gives 3 stages.
  logic [63:0] in_data_a;
  logic [2:0]  in_sel_a, out_sel_a;
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [7:0]  out_data_a;

  // Sweep instance B: INPUTS=2, LPS=1, which gives 1 stage.
  logic [15:0] in_data_b;
  logic        in_sel_b, out_sel_b;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [7:0]  out_data_b;

  // Sweep instance C: INPUTS=32, LPS=2, which gives 3 stages.
  logic [255:0] in_data_c;
  logic [4:0]   in_sel_c, out_sel_c;
  logic         in_valid_c, in_ready_c, out_valid_c, out_ready_c;
  logic [7:0]   out_data_c;

  mux_pipelined #(.DATA_W(8), .INPUTS(8), .LEVELS_PER_STAGE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_data(in_data_a), .in_sel(in_sel_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .out_data(out_data_a),
    .out_sel(out_sel_a), .out_valid(out_valid_a), .out_ready(out_ready_a));

  mux_pipelined #(.DATA_W(8), .INPUTS(2), .LEVELS_PER_STAGE(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_data(in_data_b), .in_sel(in_sel_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_sel(out_sel_b), .out_valid(out_valid_b), .out_ready(out_ready_b));

  mux_pipelined #(.DATA_W(8), .INPUTS(32), .LEVELS_PER_STAGE(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .in_data(in_data_c), .in_sel(in_sel_c),
    .in_valid(in_valid_c), .in_ready(in_ready_c), .out_data(out_data_c),
    .out_sel(out_sel_c), .out_valid(out_valid_c), .out_ready(out_ready_c));

  int n_asserts = 0;
  int n_fail    = 0;

  logic [8:0]  exp_q_b[$];   // {sel, data}
  logic [12:0] exp_q_c[$];   // {sel, data}
  logic [12:0] exp_c;
  logic [8:0]  exp_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out_a(input string tag, input logic v, input logic [7:0] d, input logic [2:0] s);
    check({tag, "_valid"}, 32'(out_valid_a), 32'(v));
    if (v) begin
      check({tag, "_data"}, 32'(out_data_a), 32'(d));
      check({tag, "_sel"},  32'(out_sel_a),  32'(s));
    end
  endtask

  // Safety net in case the stimulus sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- clock/reset and idle inputs ----------------
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) in_data_a[i*8 +: 8] = 8'hA0 + 8'(i);
    in_sel_a = '0; in_valid_a = 0; out_ready_a = 0;
    in_data_b = '0; in_sel_b = 0; in_valid_b = 0; out_ready_b = 0;
    in_data_c = '0; in_sel_c = '0; in_valid_c = 0; out_ready_c = 0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_out_data",  32'(out_data_a),  32'd0);
    check("rst_out_sel",   32'(out_sel_a),   32'd0);
    check("rst_in_ready",  32'(in_ready_a),  32'd1);
    check("rst_b_valid",   32'(out_valid_b), 32'd0);
    check("rst_c_valid",   32'(out_valid_c), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    tick();

    // ---------------- latency: one word with sel=5 ----------------
    out_ready_a = 1; in_sel_a = 3'd5; in_valid_a = 1;
    tick();
    in_valid_a = 0;
    check_out_a("lat_c1", 1'b0, 8'h00, 3'd0);
    tick();
    check_out_a("lat_c2", 1'b0, 8'h00, 3'd0);
    tick();
    check_out_a("lat_c3", 1'b1, 8'hA5, 3'd5);
    tick();
    check_out_a("lat_c4", 1'b0, 8'h00, 3'd0);

    // ---------------- throughput: sel 0..7 back to back ----------------
    for (int i = 0; i < 8; i++) begin
      in_valid_a = 1; in_sel_a = 3'(i);
      #1 check("thr_in_ready", 32'(in_ready_a), 32'd1);
      tick();
      if (i >= 2) check_out_a("thr_out", 1'b1, 8'hA0 + 8'(i - 2), 3'(i - 2));
      else        check_out_a("thr_fill", 1'b0, 8'h00, 3'd0);
    end
    in_valid_a = 0;
    tick(); check_out_a("thr_out6", 1'b1, 8'hA6, 3'd6);
    tick(); check_out_a("thr_out7", 1'b1, 8'hA7, 3'd7);
    tick(); check_out_a("thr_empty", 1'b0, 8'h00, 3'd0);

    // ---------------- backpressure: 7,3,1,6 ----------------
    in_valid_a = 1;
    in_sel_a = 3'd7; tick();
    in_sel_a = 3'd3; tick();
    in_sel_a = 3'd1; tick();
    check_out_a("bp_first", 1'b1, 8'hA7, 3'd7);
    out_ready_a = 0; in_sel_a = 3'd6;
    #1 check("bp_full_in_ready", 32'(in_ready_a), 32'd0);
    for (int s = 0; s < 4; s++) begin
      tick();
      check_out_a("bp_hold", 1'b1, 8'hA7, 3'd7);
      check("bp_hold_in_ready", 32'(in_ready_a), 32'd0);
    end
    out_ready_a = 1;
    #1 check("bp_release_in_ready", 32'(in_ready_a), 32'd1);
    tick(); check_out_a("bp_out3", 1'b1, 8'hA3, 3'd3);
    in_valid_a = 0;
    tick(); check_out_a("bp_out1", 1'b1, 8'hA1, 3'd1);
    tick(); check_out_a("bp_out6", 1'b1, 8'hA6, 3'd6);
    tick(); check_out_a("bp_empty", 1'b0, 8'h00, 3'd0);

    // ---------------- bubbles collapse under a stalled output ----------------
    out_ready_a = 0;
    in_valid_a = 1; in_sel_a = 3'd2;
    #1 check("bub_rdy1", 32'(in_ready_a), 32'd1);
    tick();
    in_valid_a = 0;
    #1 check("bub_rdy2", 32'(in_ready_a), 32'd1);
    tick();
    in_valid_a = 1; in_sel_a = 3'd4;
    #1 check("bub_rdy3", 32'(in_ready_a), 32'd1);
    tick();
    check_out_a("bub_out2", 1'b1, 8'hA2, 3'd2);
    in_valid_a = 0;
    #1 check("bub_rdy4", 32'(in_ready_a), 32'd1);
    tick();
    check_out_a("bub_hold2", 1'b1, 8'hA2, 3'd2);
    in_valid_a = 1; in_sel_a = 3'd6;
    #1 check("bub_two_held_rdy", 32'(in_ready_a), 32'd1);
    tick();
    in_valid_a = 0;
    #1 check("bub_full_rdy", 32'(in_ready_a), 32'd0);
    check_out_a("bub_full_out", 1'b1, 8'hA2, 3'd2);
    out_ready_a = 1;
    tick(); check_out_a("bub_out4", 1'b1, 8'hA4, 3'd4);
    tick(); check_out_a("bub_out6", 1'b1, 8'hA6, 3'd6);
    tick(); check_out_a("bub_empty", 1'b0, 8'h00, 3'd0);

    // ---------------- reset mid-stream with 3 words in flight ----------------
    in_valid_a = 1;
    in_sel_a = 3'd1; tick();
    in_sel_a = 3'd2; tick();
    in_sel_a = 3'd3; tick();
    in_valid_a = 0;
    check_out_a("rst_pre", 1'b1, 8'hA1, 3'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid",    32'(out_valid_a), 32'd0);
    check("rst_mid_data",     32'(out_data_a),  32'd0);
    check("rst_mid_in_ready", 32'(in_ready_a),  32'd1);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_post_valid", 32'(out_valid_a), 32'd0);
    end

    // ---------------- sweep B/C: directed latency ----------------
    in_data_b = 16'h5AC3; in_sel_b = 1'b1; in_valid_b = 1; out_ready_b = 1;
    tick();
    in_valid_b = 0;
    check("b_lat_valid", 32'(out_valid_b), 32'd1);
    check("b_lat_data",  32'(out_data_b),  32'h5A);
    check("b_lat_sel",   32'(out_sel_b),   32'd1);
    tick();
    check("b_lat_after", 32'(out_valid_b), 32'd0);

    for (int i = 0; i < 32; i++) in_data_c[i*8 +: 8] = 8'(i * 7 + 3);
    in_sel_c = 5'd19; in_valid_c = 1; out_ready_c = 1;
    tick();
    in_valid_c = 0;
    check("c_lat_c1", 32'(out_valid_c), 32'd0);
    tick();
    check("c_lat_c2", 32'(out_valid_c), 32'd0);
    tick();
    check("c_lat_valid", 32'(out_valid_c), 32'd1);
    check("c_lat_data",  32'(out_data_c),  32'h88);
    check("c_lat_sel",   32'(out_sel_c),   32'd19);
    tick();
    check("c_lat_after", 32'(out_valid_c), 32'd0);

    // ---------------- sweep B/C: random traffic against scoreboard ----------------
    for (int cyc = 0; cyc < 300; cyc++) begin
      in_valid_b  = 1'($urandom_range(0, 1));
      in_sel_b    = 1'($urandom_range(0, 1));
      in_data_b   = 16'($urandom_range(0, 65535));
      out_ready_b = ($urandom_range(0, 3) != 0);
      in_valid_c  = 1'($urandom_range(0, 1));
      in_sel_c    = 5'($urandom_range(0, 31));
      for (int i = 0; i < 32; i++) in_data_c[i*8 +: 8] = 8'($urandom_range(0, 255));
      out_ready_c = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid_b && out_ready_b) begin
        check("b_q_nonempty", 32'(exp_q_b.size() != 0), 32'd1);
        if (exp_q_b.size() != 0) begin
          exp_b = exp_q_b.pop_front();
          check("b_word", 32'({out_sel_b, out_data_b}), 32'(exp_b));
        end
      end
      if (out_valid_c && out_ready_c) begin
        check("c_q_nonempty", 32'(exp_q_c.size() != 0), 32'd1);
        if (exp_q_c.size() != 0) begin
          exp_c = exp_q_c.pop_front();
          check("c_word", 32'({out_sel_c, out_data_c}), 32'(exp_c));
        end
      end
      if (in_valid_b && in_ready_b) exp_q_b.push_back({in_sel_b, in_data_b[in_sel_b*8 +: 8]});
      if (in_valid_c && in_ready_c) exp_q_c.push_back({in_sel_c, in_data_c[in_sel_c*8 +: 8]});
      tick();
    end

    // Drain both instances with the output always ready.
    in_valid_b = 0; in_valid_c = 0; out_ready_b = 1; out_ready_c = 1;
    for (int t = 0; t < 8; t++) begin
      if (out_valid_b && exp_q_b.size() != 0) begin
        exp_b = exp_q_b.pop_front();
        check("b_drain_word", 32'({out_sel_b, out_data_b}), 32'(exp_b));
      end
      if (out_valid_c && exp_q_c.size() != 0) begin
        exp_c = exp_q_c.pop_front();
        check("c_drain_word", 32'({out_sel_c, out_data_c}), 32'(exp_c));
      end
      tick();
    end
    check("b_drain_empty", 32'(exp_q_b.size()), 32'd0);
    check("c_drain_empty", 32'(exp_q_c.size()), 32'd0);
    check("b_idle_valid",  32'(out_valid_b), 32'd0);
    check("c_idle_valid",  32'(out_valid_c), 32'd0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
